// File: rtl/fp_pkg.sv
// Shared constants and helpers for the fixed-point MAC datapath.
package fp_pkg;

    localparam int ROUND_TRUNC   = 0;
    localparam int ROUND_HALF_UP = 1;

    // Right shift that takes a full-precision product back to output scaling.
    function automatic int fp_shift(input int w_in_f, input int w_out_f);
        return 2 * w_in_f - w_out_f;
    endfunction

    function automatic longint fp_smax(input int width);
        return (longint'(1) <<< (width - 1)) - longint'(1);
    endfunction

    function automatic longint fp_smin(input int width);
        return -(longint'(1) <<< (width - 1));
    endfunction

endpackage

// File: rtl/fp_round_sat.sv
// Combinational rescale of a wide signed accumulator to a narrow Q-format word,
// with optional round-half-up and saturation flags.
module fp_round_sat
    import fp_pkg::*;
#(
    parameter int W_acc = 32,
    parameter int W_out = 16,
    parameter int SHIFT = 14,
    parameter int ROUND = ROUND_HALF_UP
) (
    input  logic [W_acc-1:0] acc_i,
    output logic [W_out-1:0] result_o,
    output logic             ovf_o,
    output logic             unf_o
);

    // One guard bit so the rounding bias can never wrap the accumulator maximum.
    localparam int WX = W_acc + 1;
    localparam logic signed [WX-1:0] BIAS =
        (ROUND == ROUND_HALF_UP) ? WX'(longint'(1) <<< (SHIFT - 1)) : '0;
    localparam logic signed [WX-1:0] MAX_OUT = WX'(fp_smax(W_out));
    localparam logic signed [WX-1:0] MIN_OUT = WX'(fp_smin(W_out));

    logic signed [WX-1:0] accExt;
    logic signed [WX-1:0] shifted;

    always_comb begin
        accExt   = {acc_i[W_acc-1], acc_i};
        shifted  = (accExt + BIAS) >>> SHIFT;
        result_o = shifted[W_out-1:0];
        ovf_o    = 1'b0;
        unf_o    = 1'b0;
        if (shifted > MAX_OUT) begin
            result_o = MAX_OUT[W_out-1:0];
            ovf_o    = 1'b1;
        end else if (shifted < MIN_OUT) begin
            result_o = MIN_OUT[W_out-1:0];
            unf_o    = 1'b1;
        end
    end

endmodule

// File: rtl/fp_mac_pipe.sv
// Three-stage pipelined signed fixed-point multiply-accumulate with valid/ready
// on both sides and sticky per-vector saturation flags.
module fp_mac_pipe
    import fp_pkg::*;
#(
    parameter int W_in    = 16,
    parameter int W_in_F  = 14,
    parameter int W_out   = 16,
    parameter int W_out_F = 14,
    parameter int W_acc   = 32,
    parameter int ROUND   = ROUND_HALF_UP
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [W_in-1:0]  a_i,
    input  logic [W_in-1:0]  b_i,
    input  logic             clear_i,
    input  logic             last_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [W_out-1:0] result_o,
    output logic             overflow_o,
    output logic             underflow_o
);

    localparam int SHIFT  = fp_shift(W_in_F, W_out_F);
    localparam int W_prod = 2 * W_in;
    localparam int WS     = W_acc + 1;
    localparam logic signed [WS-1:0] ACC_MAX = WS'(fp_smax(W_acc));
    localparam logic signed [WS-1:0] ACC_MIN = WS'(fp_smin(W_acc));

    logic                     en;

    logic                     s1Valid_q;
    logic signed [W_prod-1:0] s1Prod_q;
    logic                     s1Clear_q;
    logic                     s1Last_q;

    logic                     s2Valid_q;
    logic                     s2Last_q;
    logic signed [W_acc-1:0]  acc_q;
    logic                     accOvf_q;
    logic                     accUnf_q;

    logic                     outValid_q;
    logic [W_out-1:0]         result_q;
    logic                     overflow_q;
    logic                     underflow_q;

    logic signed [W_prod-1:0] aExt;
    logic signed [W_prod-1:0] bExt;
    logic signed [W_prod-1:0] prod_d;
    logic signed [W_acc-1:0]  prodExt;
    logic signed [WS-1:0]     sum;
    logic signed [W_acc-1:0]  acc_d;
    logic                     accOvf_d;
    logic                     accUnf_d;

    logic [W_out-1:0]         rsResult;
    logic                     rsOvf;
    logic                     rsUnf;

    // The whole pipe moves as one: it stalls only when a result is waiting unclaimed.
    assign en         = ~outValid_q | out_ready_i;
    assign in_ready_o = en;

    assign aExt   = {{W_in{a_i[W_in-1]}}, a_i};
    assign bExt   = {{W_in{b_i[W_in-1]}}, b_i};
    assign prod_d = aExt * bExt;

    // Saturating accumulate; a clear sample restarts both the sum and its sticky flags.
    always_comb begin
        prodExt  = W_acc'(s1Prod_q);
        sum      = WS'(acc_q) + WS'(prodExt);
        acc_d    = acc_q;
        accOvf_d = accOvf_q;
        accUnf_d = accUnf_q;
        if (s1Clear_q) begin
            acc_d    = prodExt;
            accOvf_d = 1'b0;
            accUnf_d = 1'b0;
        end else if (sum > ACC_MAX) begin
            acc_d    = ACC_MAX[W_acc-1:0];
            accOvf_d = 1'b1;
        end else if (sum < ACC_MIN) begin
            acc_d    = ACC_MIN[W_acc-1:0];
            accUnf_d = 1'b1;
        end else begin
            acc_d    = sum[W_acc-1:0];
        end
    end

    fp_round_sat #(
        .W_acc (W_acc),
        .W_out (W_out),
        .SHIFT (SHIFT),
        .ROUND (ROUND)
    ) u_round_sat (
        .acc_i    (acc_q),
        .result_o (rsResult),
        .ovf_o    (rsOvf),
        .unf_o    (rsUnf)
    );

    // Reset drops any partial sum and any unclaimed result along with the valids.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1Valid_q   <= 1'b0;
            s1Prod_q    <= '0;
            s1Clear_q   <= 1'b0;
            s1Last_q    <= 1'b0;
            s2Valid_q   <= 1'b0;
            s2Last_q    <= 1'b0;
            acc_q       <= '0;
            accOvf_q    <= 1'b0;
            accUnf_q    <= 1'b0;
            outValid_q  <= 1'b0;
            result_q    <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (en) begin
            s1Valid_q <= in_valid_i;
            if (in_valid_i) begin
                s1Prod_q  <= prod_d;
                s1Clear_q <= clear_i;
                s1Last_q  <= last_i;
            end

            s2Valid_q <= s1Valid_q;
            if (s1Valid_q) begin
                acc_q    <= acc_d;
                accOvf_q <= accOvf_d;
                accUnf_q <= accUnf_d;
                s2Last_q <= s1Last_q;
            end

            // Result registers only change when a finished vector arrives.
            outValid_q <= s2Valid_q & s2Last_q;
            if (s2Valid_q & s2Last_q) begin
                result_q    <= rsResult;
                overflow_q  <= rsOvf | accOvf_q;
                underflow_q <= rsUnf | accUnf_q;
            end
        end
    end

    assign out_valid_o = outValid_q;
    assign result_o    = result_q;
    assign overflow_o  = overflow_q;
    assign underflow_o = underflow_q;

endmodule

// File: tb/tb_fp_mac_pipe.sv
// Bench for fp_mac_pipe: one round-half-up and one truncating instance share the
// stimulus; an arithmetic model plus literal expectations check both every cycle.
module tb_fp_mac_pipe;

    localparam int     W_IN_F  = 14;
    localparam int     W_OUT_F = 14;
    localparam int     SHIFT   = 2 * W_IN_F - W_OUT_F;
    localparam longint ACC_MAX = 64'sd2147483647;
    localparam longint ACC_MIN = -64'sd2147483648;
    localparam longint OUT_MAX = 64'sd32767;
    localparam longint OUT_MIN = -64'sd32768;

    typedef struct {
        int          idx;
        logic [15:0] rR;
        logic [15:0] rT;
        bit          oR;
        bit          uR;
        bit          oT;
        bit          uT;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inValid = 1'b0;
    logic        clear = 1'b0;
    logic        last = 1'b0;
    logic        outReady = 1'b1;
    logic [15:0] a = '0;
    logic [15:0] b = '0;

    logic        inReadyR, outValidR, ovfR, unfR;
    logic [15:0] resR;
    logic        inReadyT, outValidT, ovfT, unfT;
    logic [15:0] resT;

    int     total = 0;
    int     bad = 0;
    int     cycleCnt = 0;
    int     takeCount = 0;
    int     advCnt = 0;
    longint mAcc = 0;
    bit     mOvf = 0;
    bit     mUnf = 0;
    bit     due;
    bit     en;
    exp_t   expQ[$];

    always #5 clk = ~clk;
    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    fp_mac_pipe #(.ROUND(1)) dutR (
        .clk_i(clk), .rst_i(rst), .in_valid_i(inValid), .in_ready_o(inReadyR),
        .a_i(a), .b_i(b), .clear_i(clear), .last_i(last),
        .out_valid_o(outValidR), .out_ready_i(outReady),
        .result_o(resR), .overflow_o(ovfR), .underflow_o(unfR)
    );

    fp_mac_pipe #(.ROUND(0)) dutT (
        .clk_i(clk), .rst_i(rst), .in_valid_i(inValid), .in_ready_o(inReadyT),
        .a_i(a), .b_i(b), .clear_i(clear), .last_i(last),
        .out_valid_o(outValidT), .out_ready_i(outReady),
        .result_o(resT), .overflow_o(ovfT), .underflow_o(unfT)
    );

    task automatic checkBit(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic checkWord(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%h expected 0x%h", name, act, exp);
        end
    endtask

    task automatic checkInt(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Real-valued meaning: scale down by 2^SHIFT, round or floor, clamp to the output range.
    function automatic void roundSat(input longint acc, input bit aO, input bit aU, input bit rnd,
                                     output logic [15:0] r, output bit o, output bit u);
        longint v;
        v = rnd ? ((acc + (longint'(1) <<< (SHIFT - 1))) >>> SHIFT) : (acc >>> SHIFT);
        o = aO;
        u = aU;
        if (v > OUT_MAX) begin
            v = OUT_MAX;
            o = 1'b1;
        end else if (v < OUT_MIN) begin
            v = OUT_MIN;
            u = 1'b1;
        end
        r = v[15:0];
    endfunction

    task automatic acceptSample(input int idx);
        longint pa, pb, p, s;
        exp_t   e;
        pa = longint'($signed(a));
        pb = longint'($signed(b));
        p  = pa * pb;
        if (clear) begin
            mAcc = p;
            mOvf = 1'b0;
            mUnf = 1'b0;
        end else begin
            s = mAcc + p;
            if (s > ACC_MAX) begin
                mAcc = ACC_MAX;
                mOvf = 1'b1;
            end else if (s < ACC_MIN) begin
                mAcc = ACC_MIN;
                mUnf = 1'b1;
            end else begin
                mAcc = s;
            end
        end
        if (last) begin
            e.idx = idx;
            roundSat(mAcc, mOvf, mUnf, 1'b1, e.rR, e.oR, e.uR);
            roundSat(mAcc, mOvf, mUnf, 1'b0, e.rT, e.oT, e.uT);
            expQ.push_back(e);
        end
    endtask

    // Model of the handshake: a result is due three advancing cycles after its last sample.
    always @(negedge clk) begin
        if (rst) begin
            mAcc = 0;
            mOvf = 1'b0;
            mUnf = 1'b0;
            expQ.delete();
        end else begin
            due = (expQ.size() > 0) && (expQ[0].idx + 3 <= advCnt);
            en  = !due || outReady;
            checkBit("in_ready R", inReadyR, en);
            checkBit("in_ready T", inReadyT, en);
            checkBit("out_valid R", outValidR, due);
            checkBit("out_valid T", outValidT, due);
            if (due) begin
                checkWord("model result R", resR, expQ[0].rR);
                checkWord("model result T", resT, expQ[0].rT);
                checkBit("model ovf R", ovfR, expQ[0].oR);
                checkBit("model unf R", unfR, expQ[0].uR);
                checkBit("model ovf T", ovfT, expQ[0].oT);
                checkBit("model unf T", unfT, expQ[0].uT);
                if (outReady) begin
                    void'(expQ.pop_front());
                    takeCount++;
                end
            end
            if (en) begin
                if (inValid) acceptSample(advCnt);
                advCnt++;
            end
        end
    end

    task automatic applyStimulus(input logic [15:0] av, input logic [15:0] bv,
                                 input logic clr, input logic lst);
        bit ok;
        a       = av;
        b       = bv;
        clear   = clr;
        last    = lst;
        inValid = 1'b1;
        ok      = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            ok = inReadyR;
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            total++;
            bad++;
            $display("[TB] FAIL accept timeout: got no in_ready expected acceptance within 40 cycles");
            inValid = 1'b0;
        end
    endtask

    task automatic idle();
        inValid = 1'b0;
        clear   = 1'b0;
        last    = 1'b0;
    endtask

    task automatic checkOutput(input string name, input logic [15:0] expR, input logic [15:0] expT,
                               input logic expOvf, input logic expUnf, output int seenCycle);
        bit found;
        found     = 1'b0;
        seenCycle = -1;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (outValidR && outReady) begin
                found     = 1'b1;
                seenCycle = cycleCnt;
                checkWord({name, " result R"}, resR, expR);
                checkWord({name, " result T"}, resT, expT);
                checkBit({name, " ovf R"}, ovfR, expOvf);
                checkBit({name, " unf R"}, unfR, expUnf);
                checkBit({name, " ovf T"}, ovfT, expOvf);
                checkBit({name, " unf T"}, unfT, expUnf);
            end
        end
        if (!found) begin
            total++;
            bad++;
            $display("[TB] FAIL %s timeout: got no out_valid expected a result within 40 cycles", name);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no end of test expected finish before 200us");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int c0, sc, base;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        checkBit("reset out_valid", outValidR, 1'b0);
        checkWord("reset result", resR, 16'h0000);
        checkBit("reset ovf", ovfR, 1'b0);
        checkBit("reset unf", unfR, 1'b0);
        checkBit("reset in_ready", inReadyR, 1'b1);
        checkWord("reset result T", resT, 16'h0000);

        // 0.5 * -1.75
        applyStimulus(16'h2000, 16'h9000, 1'b1, 1'b1);
        idle();
        c0 = cycleCnt;
        checkOutput("t1", 16'hC800, 16'hC800, 1'b0, 1'b0, sc);
        checkInt("t1 latency", sc - c0, 2);

        // 4 x 2.25 = 9 exceeds the accumulator range of +8
        applyStimulus(16'h6000, 16'h6000, 1'b1, 1'b0);
        applyStimulus(16'h6000, 16'h6000, 1'b0, 1'b0);
        applyStimulus(16'h6000, 16'h6000, 1'b0, 1'b0);
        applyStimulus(16'h6000, 16'h6000, 1'b0, 1'b1);
        idle();
        checkOutput("t2 acc sat", 16'h7FFF, 16'h7FFF, 1'b1, 1'b0, sc);

        applyStimulus(16'h6000, 16'h6000, 1'b1, 1'b0);
        applyStimulus(16'hC000, 16'h4000, 1'b0, 1'b1);
        idle();
        checkOutput("t3 mixed", 16'h5000, 16'h5000, 1'b0, 1'b0, sc);

        // No clear: continues from 1.25, giving 2.25 which only the output range rejects
        applyStimulus(16'h4000, 16'h4000, 1'b0, 1'b1);
        idle();
        checkOutput("t3 continue", 16'h7FFF, 16'h7FFF, 1'b1, 1'b0, sc);

        applyStimulus(16'h0001, 16'h2000, 1'b1, 1'b1);
        idle();
        checkOutput("t4 half pos", 16'h0001, 16'h0000, 1'b0, 1'b0, sc);
        applyStimulus(16'h0001, 16'hE000, 1'b1, 1'b1);
        idle();
        checkOutput("t4 half neg", 16'h0000, 16'hFFFF, 1'b0, 1'b0, sc);

        // 3 x -3.5 = -10.5 below the accumulator range of -8
        applyStimulus(16'h8000, 16'h7000, 1'b1, 1'b0);
        applyStimulus(16'h8000, 16'h7000, 1'b0, 1'b0);
        applyStimulus(16'h8000, 16'h7000, 1'b0, 1'b1);
        idle();
        checkOutput("acc underflow", 16'h8000, 16'h8000, 1'b0, 1'b1, sc);

        // Saturated accumulator pulled back into range keeps its sticky overflow
        applyStimulus(16'h6000, 16'h6000, 1'b1, 1'b0);
        applyStimulus(16'h6000, 16'h6000, 1'b0, 1'b0);
        applyStimulus(16'h6000, 16'h6000, 1'b0, 1'b0);
        applyStimulus(16'h6000, 16'h6000, 1'b0, 1'b0);
        applyStimulus(16'h8000, 16'h7FFF, 1'b0, 1'b0);
        applyStimulus(16'h8000, 16'h7FFF, 1'b0, 1'b1);
        idle();
        checkOutput("sticky ovf", 16'h0004, 16'h0003, 1'b1, 1'b0, sc);

        applyStimulus(16'h8000, 16'h4000, 1'b1, 1'b1);
        idle();
        checkOutput("exact min", 16'h8000, 16'h8000, 1'b0, 1'b0, sc);

        // Backpressure: hold out_ready low for five cycles with a result waiting
        outReady = 1'b0;
        base = takeCount;
        fork
            begin
                applyStimulus(16'h2000, 16'h9000, 1'b1, 1'b1);
                applyStimulus(16'h4000, 16'h4000, 1'b1, 1'b1);
                applyStimulus(16'h6000, 16'h2000, 1'b1, 1'b1);
                applyStimulus(16'hC000, 16'h2000, 1'b1, 1'b1);
                idle();
            end
            begin
                repeat (6) @(posedge clk);
                #1;
                checkBit("stall in_ready", inReadyR, 1'b0);
                checkBit("stall out_valid", outValidR, 1'b1);
                checkWord("stall result", resR, 16'hC800);
                repeat (2) @(posedge clk);
                #1;
                outReady = 1'b1;
            end
        join
        repeat (8) @(posedge clk);
        #1;
        checkInt("stall results delivered", takeCount - base, 4);

        base = takeCount;
        c0 = cycleCnt;
        applyStimulus(16'h1000, 16'h4000, 1'b1, 1'b1);
        applyStimulus(16'h7FFF, 16'h7FFF, 1'b1, 1'b1);
        applyStimulus(16'h8000, 16'h8000, 1'b1, 1'b1);
        applyStimulus(16'h0003, 16'h2000, 1'b1, 1'b1);
        applyStimulus(16'hFFFF, 16'h0001, 1'b1, 1'b1);
        applyStimulus(16'h8000, 16'h4000, 1'b1, 1'b1);
        idle();
        checkInt("full rate accept cycles", cycleCnt - c0, 6);
        repeat (4) @(posedge clk);
        #1;
        checkInt("full rate results", takeCount - base, 6);

        // Reset mid-vector: partial sum discarded, next non-clear vector starts from zero
        applyStimulus(16'h2000, 16'h2000, 1'b1, 1'b0);
        applyStimulus(16'h2000, 16'h2000, 1'b0, 1'b0);
        idle();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkBit("mid reset out_valid", outValidR, 1'b0);
        checkWord("mid reset result", resR, 16'h0000);
        checkWord("mid reset result T", resT, 16'h0000);
        checkBit("mid reset ovf", ovfR, 1'b0);
        checkBit("mid reset unf", unfR, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        applyStimulus(16'h2000, 16'h2000, 1'b0, 1'b1);
        idle();
        checkOutput("after reset acc", 16'h1000, 16'h1000, 1'b0, 1'b0, sc);
        applyStimulus(16'h2000, 16'h9000, 1'b1, 1'b1);
        idle();
        checkOutput("after reset fresh", 16'hC800, 16'hC800, 1'b0, 1'b0, sc);

        repeat (5) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
